fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-domain consumer end of the async FIFO; the streaming reader for the FIFO memory.
- Synchronizes the write-domain Gray pointer into rclk and drives the dual-port memory read port.
- Presents first-word-fall-through data on a valid/ready stream through a 2-entry output buffer.
- Returns the Gray read pointer to the write domain and reports fill level and almost-empty.

Parameters:
ASIZE, 4, memory address width; depth = 2^ASIZE
DSIZE, 8, data width
AEMPTY_THRESH, 2, raempty asserts when rlevel <= this value

Ports:
rclk  in  1  read clock
rrst_n  in  1  reset; asynchronous, active-low
wptr_gray  in  ASIZE+1  write pointer, Gray-coded, from wclk domain (asynchronous)
rptr  out  ASIZE+1  read pointer, Gray-coded, registered, to write-domain synchronizer
raddr  out  ASIZE  memory read address (binary)
rclken  out  1  memory read enable
rdata_mem  in  DSIZE  memory read data, valid the cycle after rclken
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts; pop = m_valid & m_ready
m_data  out  DSIZE  output word
rlevel  out  ASIZE+2  registered total words held (memory + in flight + buffer)
raempty  out  1  registered almost-empty

Behaviour:
- Reset: sync1/sync2 = 0, rbin = 0, rptr = 0, s1_valid = 0, buf_cnt = 0, m_valid = 0, m_data = 0, rlevel = 0, raempty = 1. Async assert; deassert sync'd externally.
- Synchronizer: 2 flops in rclk, no logic between. wbin_s = Gray-to-binary(sync2), combinational.
- mem_cnt = (wbin_s - rbin) mod 2^(ASIZE+1); mem_nonempty = (mem_cnt != 0). Full-pointer compare including MSB distinguishes wrap.
- Issue: issue = mem_nonempty & ((s1_valid + buf_cnt - pop) < 2). rclken = issue (combinational); raddr = rbin[ASIZE-1:0].
- On issue: rbin <= rbin + 1; rptr <= gray(rbin + 1) in the same edge. rbin wraps 2^(ASIZE+1)-1 -> 0.
- s1_valid <= issue. When s1_valid, rdata_mem is written into the buffer at the next edge.
- Output buffer, 2 entries: out reg (m_data/m_valid) and skid reg. Strict FIFO order.
  - Write goes to out reg if out reg is empty or being popped with skid empty; otherwise to skid.
  - On pop with skid full, skid moves to out reg.
  - buf_cnt never exceeds 2; the issue rule guarantees no overflow.
- Throughput: 1 word/rclk sustained when m_ready = 1 and memory is nonempty.
- Latency, empty to first word: wptr_gray change sampled at edge E1.
  - Edge E2: sync2 is updated and rclken is high in the following cycle.
  - Edge E3: the memory read is taken.
  - Edge E4: m_valid = 1.
- m_data is held stable while m_valid & ~m_ready. m_valid never drops without a pop.
- rlevel <= mem_cnt_next + s1_valid_next + buf_cnt_next, registered, one cycle behind. Max 2^ASIZE + 2.
- raempty <= (rlevel_next <= AEMPTY_THRESH).
- Simultaneous issue and pop: both take effect; buf_cnt nets correctly.
- A Gray wptr mid-transition may sample old or new. Either yields a monotonic count; no false data.
- Reset mid-operation: in-flight read and buffer contents are discarded. The writer must be reset in the same episode.

Test Plan:
- Reset with wptr_gray = 0 -> rptr = 0, m_valid = 0, rlevel = 0, raempty = 1, rclken = 0 for 10 cycles.
- wptr_gray 00000 -> 00001, mem[0] = 0xA5, m_ready = 1 -> one rclken pulse with raddr = 0.
  - m_valid = 1 with m_data = 0xA5 at the 4th edge after sampling.
  - Afterwards rptr = 00001, rlevel returns to 0.
- 16 words written, m_ready = 1 -> after first word, m_valid high 16 consecutive cycles with data in order.
  - rptr ends at 11000 (gray of 16); raddr wraps 15 -> 0.
- 5 words present, m_ready = 0 -> exactly 2 rclken pulses, then rclken = 0.
  - m_data holds word 0; rlevel = 5; raempty = 0 with AEMPTY_THRESH = 2.
- Drain from 3 words with m_ready toggling 1,0,1,1 -> words pop in order; no duplicates or drops.
  - raempty rises when rlevel reaches 2.
- Assert rrst_n low mid-burst with buf_cnt = 2 -> immediately m_valid = 0, rptr = 0, rlevel = 0, raempty = 1.
  - A fresh single-word transfer works after release.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-domain end of the async FIFO. It synchronizes the write Gray pointer,
// drives the memory read port, and presents FWFT data through a 2-deep
// out/skid buffer. It also returns the Gray read pointer and reports the fill
// level and almost-empty.
module fifo_rd_stream #(
  parameter int ASIZE         = 4,
  parameter int DSIZE         = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   wptr_gray,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             rclken,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [ASIZE+1:0] rlevel,
  output logic             raempty
);
  localparam int PW = ASIZE + 1;
  localparam int LW = ASIZE + 2;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0]    sync1_q, sync2_q, rbin_q, rbin_d, rptr_q, rptr_d;
  logic             s1_valid_q;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [DSIZE-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic [LW-1:0]    rlevel_q, rlevel_d;
  logic             raempty_q, raempty_d;

  logic [PW-1:0]    wbin_s, mem_cnt, mem_cnt_d;
  logic [1:0]       buf_cnt, buf_cnt_d;
  logic [2:0]       occ;
  logic             pop, issue;

  // Pointer arithmetic and the read-issue decision
  always_comb begin
    wbin_s    = g2b(sync2_q);
    mem_cnt   = wbin_s - rbin_q;
    pop       = out_vld_q & m_ready;
    buf_cnt   = {1'b0, out_vld_q} + {1'b0, skid_vld_q};
    // Occupancy after this edge of the slots a new read could land in.
    occ       = {2'b0, s1_valid_q} + {1'b0, buf_cnt} - {2'b0, pop};
    issue     = (mem_cnt != '0) && (occ < 3'd2);
    rbin_d    = rbin_q + PW'(issue);
    rptr_d    = rbin_d ^ (rbin_d >> 1);
    // The next sync2 value is sync1, so the next count uses it directly.
    mem_cnt_d = g2b(sync1_q) - rbin_d;
  end

  // Out/skid buffer next state; the write comes from the read issued last cycle
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (pop) begin
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        skid_vld_d = s1_valid_q;
        if (s1_valid_q) skid_data_d = rdata_mem;
      end else begin
        out_vld_d = s1_valid_q;
        if (s1_valid_q) out_data_d = rdata_mem;
      end
    end else if (s1_valid_q) begin
      if (!out_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = rdata_mem;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = rdata_mem;
      end
    end
    buf_cnt_d = {1'b0, out_vld_d} + {1'b0, skid_vld_d};
    rlevel_d  = LW'(mem_cnt_d) + LW'(issue) + LW'(buf_cnt_d);
    raempty_d = (rlevel_d <= LW'(AEMPTY_THRESH));
  end

  // State registers; reset discards any in-flight read and buffered words
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      rbin_q      <= '0;
      rptr_q      <= '0;
      s1_valid_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      rlevel_q    <= '0;
      raempty_q   <= 1'b1;
    end else begin
      sync1_q     <= wptr_gray;
      sync2_q     <= sync1_q;
      rbin_q      <= rbin_d;
      if (issue) rptr_q <= rptr_d;
      s1_valid_q  <= issue;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      rlevel_q    <= rlevel_d;
      raempty_q   <= raempty_d;
    end
  end

  assign rclken  = issue;
  assign raddr   = rbin_q[ASIZE-1:0];
  assign rptr    = rptr_q;
  assign m_valid = out_vld_q;
  assign m_data  = out_data_q;
  assign rlevel  = rlevel_q;
  assign raempty = raempty_q;
endmodule
